aud_player: RTL

AUD_PLAYER -- requirements
Module: aud_player

---
 rtl/aud_pkg.sv | 17 +
 rtl/aud_shift_out.sv | 48 ++++
 rtl/aud_player.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/aud_pkg.sv
// Shared definitions for the WM8731 audio playback path: FSM states and
// default sample/address widths.
package aud_pkg;

    localparam int SAMPLE_W_DEF = 16;
    localparam int ADDR_W_DEF   = 20;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_L,
        SEND_L,
        WAIT_R,
        SEND_R,
        PAUSE
    } state_e;

endpackage

// File: rtl/aud_shift_out.sv
// Parallel-load, MSB-first serialiser with a bit counter. It is shared by the
// left and right slots; the last bit of a sample is flagged on last_o.
module aud_shift_out
    import aud_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                load_i,
    input  logic                shift_i,
    input  logic [SAMPLE_W-1:0] data_i,
    output logic                msb_o,
    output logic                last_o
);

    localparam int CNT_W = $clog2(SAMPLE_W + 1);

    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]    count_q, count_d;

    // Load restarts the count; otherwise each shift moves one bit out.
    always_comb begin
        shift_d = shift_q;
        count_d = count_q;
        if (load_i) begin
            shift_d = data_i;
            count_d = '0;
        end else if (shift_i) begin
            shift_d = {shift_q[SAMPLE_W-2:0], 1'b0};
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift_q <= '0;
            count_q <= '0;
        end else begin
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

    assign msb_o  = shift_q[SAMPLE_W-1];
    assign last_o = (count_q == CNT_W'(SAMPLE_W - 1));

endmodule

// File: rtl/aud_player.sv
// Plays mono samples from SRAM to a WM8731 DAC in I2S format, sending each
// sample to both the left and right slots, with start/pause/stop control.
module aud_player
    import aud_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_lrc,
    input  logic                i_start,
    input  logic                i_pause,
    input  logic                i_stop,
    input  logic [ADDR_W-1:0]   i_end_addr,
    input  logic [SAMPLE_W-1:0] i_sram_data,
    output logic [ADDR_W-1:0]   o_address,
    output logic                o_dacdat,
    output logic                o_playing,
    output logic                o_finished
);

    state_e state_q, state_d;

    logic              lrc_q;
    logic              fallEdge;
    logic              riseEdge;
    logic              atEnd;
    logic              shiftLoad;
    logic              shiftEn;
    logic              shiftMsb;
    logic              shiftLast;
    logic              sampleDone;
    logic [ADDR_W-1:0] address_q, address_d;
    logic              dacdat_q, dacdat_d;
    logic              finished_q, finished_d;
    logic              pauseReq_q, pauseReq_d;

    assign fallEdge = lrc_q & ~i_lrc;
    assign riseEdge = ~lrc_q & i_lrc;
    assign atEnd    = (address_q == i_end_addr);

    aud_shift_out #(.SAMPLE_W(SAMPLE_W)) u_shift (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .load_i  (shiftLoad),
        .shift_i (shiftEn),
        .data_i  (i_sram_data),
        .msb_o   (shiftMsb),
        .last_o  (shiftLast)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stop overrides every other transition, including the end-of-sample decision.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start)   state_d = WAIT_L;
            WAIT_L:  if (fallEdge)  state_d = SEND_L;
            SEND_L:  if (shiftLast) state_d = WAIT_R;
            WAIT_R:  if (riseEdge)  state_d = SEND_R;
            SEND_R: begin
                if (shiftLast) begin
                    if (atEnd)                       state_d = IDLE;
                    else if (i_pause || pauseReq_q)  state_d = PAUSE;
                    else                             state_d = WAIT_L;
                end
            end
            PAUSE:   if (i_start)   state_d = WAIT_L;
            default:                state_d = IDLE;
        endcase
        if (i_stop) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        o_playing  = 1'b1;
        shiftLoad  = 1'b0;
        shiftEn    = 1'b0;
        sampleDone = 1'b0;
        case (state_q)
            IDLE, PAUSE: o_playing = 1'b0;
            WAIT_L:      shiftLoad = fallEdge & ~i_stop;
            SEND_L:      shiftEn   = 1'b1;
            WAIT_R:      shiftLoad = riseEdge & ~i_stop;
            SEND_R: begin
                shiftEn    = 1'b1;
                sampleDone = shiftLast;
            end
            default:     o_playing = 1'b0;
        endcase
    end

    // The address only moves at a sample boundary, well before the next load.
    always_comb begin
        address_d  = address_q;
        dacdat_d   = shiftEn ? shiftMsb : 1'b0;
        finished_d = 1'b0;
        pauseReq_d = pauseReq_q;
        if (o_playing && i_pause) begin
            pauseReq_d = 1'b1;
        end
        if (sampleDone) begin
            if (atEnd) begin
                address_d  = '0;
                finished_d = 1'b1;
            end else begin
                address_d = address_q + ADDR_W'(1);
            end
        end
        if (state_d == IDLE || state_d == PAUSE) begin
            pauseReq_d = 1'b0;
        end
        if (i_stop) begin
            address_d  = '0;
            dacdat_d   = 1'b0;
            finished_d = 1'b0;
            pauseReq_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lrc_q      <= 1'b0;
            address_q  <= '0;
            dacdat_q   <= 1'b0;
            finished_q <= 1'b0;
            pauseReq_q <= 1'b0;
        end else begin
            lrc_q      <= i_lrc;
            address_q  <= address_d;
            dacdat_q   <= dacdat_d;
            finished_q <= finished_d;
            pauseReq_q <= pauseReq_d;
        end
    end

    assign o_address  = address_q;
    assign o_dacdat   = dacdat_q;
    assign o_finished = finished_q;

endmodule
